mesh_output_interface: RTL

MESH_OUTPUT_INTERFACE -- requirements
Module: mesh_output_interface

---
 rtl/accel_pkg.sv | 18 +
 rtl/out_fifo.sv | 50 +++++
 rtl/mesh_output_interface.sv | 108 ++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared types and sizing for the mesh output interface.
package accel_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned OUT_FIFO_DEPTH = 4;
  localparam int unsigned SYS_BEATS      = 4;
  localparam int unsigned DIRECT_BEATS   = 2;
  localparam int unsigned BEAT_W         = 3;
  localparam int unsigned SKEW_W         = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCapture,
    StDrain
  } out_state_t;

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO with the head word taken straight from storage flops.
module out_fifo
  import accel_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = $clog2(OUT_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [OUT_FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CntW'(OUT_FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mesh_output_interface.sv
// Captures mesh south-edge results (skewed systolic or direct) into an output FIFO.
// Define MESH_OUTPUT_RELU_EN to clamp negative captured words to zero before the push.
module mesh_output_interface
  import accel_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              systolic,
  input  logic [SKEW_W-1:0] delay_col,
  input  logic [DATA_W-1:0] data_input_south,
  input  logic              data_valid_south,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  out_state_t        state_q, state_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              sys_q, sys_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, full, empty, accept;
  logic [DATA_W-1:0] push_data;

`ifdef MESH_OUTPUT_RELU_EN
  assign push_data = data_input_south[DATA_W-1] ? '0 : data_input_south;
`else
  assign push_data = data_input_south;
`endif

  assign pop       = out_valid & out_ready;
  assign out_valid = ~empty;
  assign busy      = (state_q != StIdle);
  assign overflow  = overflow_q;

  always_comb begin
    state_d = state_q;
    skew_d  = skew_q;
    beats_d = beats_q;
    sys_d   = sys_q;
    push    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          sys_d   = systolic;
          skew_d  = delay_col;
          beats_d = '0;
          state_d = (systolic && delay_col != '0) ? StWait : StCapture;
        end
      end
      StWait: begin
        skew_d = skew_q - 1'b1;
        if (skew_q <= SKEW_W'(1)) state_d = StCapture;
      end
      StCapture: begin
        push = sys_q | data_valid_south;
        if (push) begin
          beats_d = beats_q + 1'b1;
          // Dropped beats still count, so a full FIFO cannot stall the capture.
          if (beats_d == BEAT_W'(sys_q ? SYS_BEATS : DIRECT_BEATS)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (empty) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    overflow_d = accept ? 1'b0 : (overflow_q | (push & full & ~pop));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      skew_q     <= '0;
      beats_q    <= '0;
      sys_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skew_q     <= skew_d;
      beats_q    <= beats_d;
      sys_q      <= sys_d;
      overflow_q <= overflow_d;
    end
  end

  out_fifo u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (out_data),
    .full      (full),
    .empty     (empty)
  );

endmodule
